// File: rtl/gpio_in_edge_irq_pkg.sv
// gpio_pkg: register map and edge-type encodings shared by the GPIO input port.
package gpio_pkg;
    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } gpio_addr_e;
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/gpio_in_edge_irq_if.sv
// gpio_in_edge_irq_if: Avalon-MM slave bus carrying the register accesses.
interface gpio_in_edge_irq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_in_edge_irq_sync_debounce.sv
// gpio_sync_debounce: single-bit synchroniser followed by an optional debounce counter.
module gpio_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    output logic o_deb
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_sync <= '0;
        else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
    assign w_sync = r_sync[SYNC_STAGES-1];
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign o_deb = w_sync;
    end else begin : g_deb
        localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
        logic [CW-1:0] r_cnt;
        logic          r_deb;
        // A change is accepted only after it has persisted for DEBOUNCE_CYCLES edges.
        always_ff @(posedge clk or negedge reset_n)
            if (!reset_n) begin
                r_cnt <= '0;
                r_deb <= 1'b0;
            end else if (w_sync == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_deb <= w_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        assign o_deb = r_deb;
    end
endmodule

// File: rtl/gpio_in_edge_irq.sv
// gpio_in_edge_irq: Avalon-MM input port with sync/debounce, edge capture and masked level IRQ.
module gpio_in_edge_irq
    import gpio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = EDGE_RISING
) (
    input  logic                    clk,
    input  logic                    reset_n,
    gpio_in_edge_irq_if.slave       bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be 2..4");
    end
    if (EDGE_TYPE < EDGE_RISING || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("EDGE_TYPE must be 0..2");
    end
    logic [WIDTH-1:0] w_deb;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      w_rdmux;
    logic [31:0]      r_readdata;
    logic             r_irq;
    logic             w_wr;
    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        gpio_sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .i_in    (in_port[g]),
            .o_deb   (w_deb[g])
        );
    end
    if (WIDTH < 32) begin : g_pad
        logic w_unused;
        assign w_unused = ^bus.writedata[31:WIDTH];
    end
    assign w_edge = EDGE_TYPE == EDGE_FALLING ? ~w_deb & r_prev :
                    EDGE_TYPE == EDGE_ANY     ?  w_deb ^ r_prev :
                                                 w_deb & ~r_prev;
    assign w_wr  = bus.chipselect & ~bus.write_n;
    assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;
    always_comb
        w_rdmux = bus.address == ADDR_DATA    ? 32'(w_deb)     :
                  bus.address == ADDR_IRQMASK ? 32'(r_irqmask) :
                  bus.address == ADDR_EDGECAP ? 32'(r_edgecap) : '0;
    // New edges are OR-ed in after the clear, so a same-cycle set beats a W1C.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            r_prev     <= '0;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= w_deb;
            if (w_wr && bus.address == ADDR_IRQMASK) r_irqmask <= bus.writedata[WIDTH-1:0];
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            r_readdata <= w_rdmux;
            r_irq      <= |(r_edgecap & r_irqmask);
        end
    assign bus.readdata = r_readdata;
    assign irq          = r_irq;
endmodule

// File: tb/tb_gpio_in_edge_irq.sv
// tb_gpio_in_edge_irq: directed checks on four configurations sharing one clock and reset.
module tb_gpio_in_edge_irq;
    logic        clk;
    logic        reset_n;
    logic [1:0]  t_addr;
    logic        t_cs;
    logic        t_wn;
    logic [31:0] t_wd;
    int          t_sel;
    logic [7:0]  pin [4];
    logic [31:0] rd [4];
    logic [3:0]  irqs;
    int          n_checks;
    int          n_errors;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // 0: DEB=0 rising, 1: DEB=4 rising, 2: DEB=0 falling, 3: DEB=0 any edge
    for (genvar g = 0; g < 4; g++) begin : g_dut
        gpio_in_edge_irq_if bus ();
        assign bus.address    = t_addr;
        assign bus.chipselect = t_cs && (t_sel == g);
        assign bus.write_n    = t_wn;
        assign bus.writedata  = t_wd;
        assign rd[g]          = bus.readdata;
        gpio_in_edge_irq #(
            .WIDTH           (8),
            .SYNC_STAGES     (2),
            .DEBOUNCE_CYCLES (g == 1 ? 4 : 0),
            .EDGE_TYPE       (g == 3 ? 2 : g == 2 ? 1 : 0)
        ) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus),
            .in_port (pin[g]),
            .irq     (irqs[g])
        );
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask
    task automatic rdc(input int n, input logic [1:0] a, input logic [31:0] exp, input string tag);
        t_sel  = n;
        t_addr = a;
        tick(1);
        check(tag, rd[n], exp);
    endtask
    task automatic wr(input int n, input logic [1:0] a, input logic [31:0] d);
        t_sel  = n;
        t_addr = a;
        t_wd   = d;
        t_cs   = 1'b1;
        t_wn   = 1'b0;
        tick(1);
        t_cs   = 1'b0;
        t_wn   = 1'b1;
    endtask
    initial begin
        int cnt;
        int first;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        t_addr   = 2'd0;
        t_cs     = 1'b0;
        t_wn     = 1'b1;
        t_wd     = '0;
        t_sel    = 0;
        pin[0]   = 8'hA5;
        pin[1]   = 8'h00;
        pin[2]   = 8'h00;
        pin[3]   = 8'h00;
        tick(3);
        for (int n = 0; n < 4; n++) begin
            check("rst_rd", rd[n], 32'h0);
            check("rst_irq", 32'(irqs[n]), 32'h0);
        end
        reset_n = 1'b1;
        tick(5);
        rdc(0, 2'd0, 32'h0000_00A5, "data_a5");
        rdc(0, 2'd1, 32'h0, "rsvd_zero");
        rdc(0, 2'd3, 32'h0000_00A5, "postrst_cap");
        check("postrst_irq", 32'(irqs[0]), 32'h0);
        wr(0, 2'd2, 32'hFFFF_FF3C);
        rdc(0, 2'd2, 32'h0000_003C, "mask_rw");
        wr(0, 2'd2, 32'h0);
        wr(0, 2'd0, 32'hFF);
        rdc(0, 2'd0, 32'h0000_00A5, "data_ro");
        wr(0, 2'd3, 32'hFF);
        rdc(0, 2'd3, 32'h0, "w1c_all");
        pin[0] = 8'h00;
        tick(4);
        pin[0] = 8'h0F;
        tick(4);
        rdc(0, 2'd3, 32'h0F, "cap_0f");
        wr(0, 2'd3, 32'h05);
        rdc(0, 2'd3, 32'h0A, "w1c_05");
        pin[0] = 8'h0D;
        tick(4);
        pin[0] = 8'h0F;
        tick(2);
        wr(0, 2'd3, 32'h02);
        rdc(0, 2'd3, 32'h0A, "set_wins");
        wr(1, 2'd2, 32'h08);
        t_sel  = 1;
        t_addr = 2'd3;
        tick(1);
        pin[1] = 8'h08;
        tick(7);
        check("lat_cap_e7", rd[1], 32'h0);
        check("lat_irq_e7", 32'(irqs[1]), 32'h0);
        tick(1);
        check("lat_cap_e8", rd[1], 32'h08);
        check("lat_irq_e8", 32'(irqs[1]), 32'h1);
        pin[1] = 8'h09;
        tick(3);
        pin[1] = 8'h08;
        tick(10);
        rdc(1, 2'd0, 32'h08, "glitch_data");
        rdc(1, 2'd3, 32'h08, "glitch_cap");
        t_addr = 2'd0;
        tick(1);
        pin[1] = 8'h09;
        cnt    = 0;
        first  = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (i == 6) pin[1] = 8'h08;
            if (rd[1][0]) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        check("pulse_len", 32'(cnt), 32'd6);
        check("pulse_start", 32'(first), 32'd7);
        rdc(1, 2'd3, 32'h09, "pulse_cap");
        wr(2, 2'd2, 32'h01);
        pin[2] = 8'h01;
        tick(5);
        rdc(2, 2'd3, 32'h0, "fall_norise");
        check("fall_noirq", 32'(irqs[2]), 32'h0);
        pin[2] = 8'h00;
        tick(5);
        rdc(2, 2'd3, 32'h01, "fall_cap");
        check("fall_irq", 32'(irqs[2]), 32'h1);
        wr(2, 2'd2, 32'h0);
        check("irq_hold", 32'(irqs[2]), 32'h1);
        tick(1);
        check("irq_unmask", 32'(irqs[2]), 32'h0);
        rdc(2, 2'd3, 32'h01, "cap_kept");
        pin[3] = 8'h80;
        tick(5);
        rdc(3, 2'd3, 32'h80, "any_rise");
        wr(3, 2'd3, 32'hFF);
        pin[3] = 8'h00;
        tick(5);
        rdc(3, 2'd3, 32'h80, "any_fall");
        pin[1] = 8'hFF;
        tick(12);
        wr(1, 2'd2, 32'hFF);
        rdc(1, 2'd3, 32'hFF, "pre_rst_cap");
        check("pre_rst_irq", 32'(irqs[1]), 32'h1);
        pin[1] = 8'hFE;
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rd", rd[1], 32'h0);
        check("async_irq", 32'(irqs[1]), 32'h0);
        pin[1] = 8'h01;
        #1;
        reset_n = 1'b1;
        tick(10);
        rdc(1, 2'd3, 32'h01, "post_rst_one");
        check("post_rst_irq", 32'(irqs[1]), 32'h0);
        wr(1, 2'd3, 32'h01);
        tick(5);
        rdc(1, 2'd3, 32'h0, "no_second");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
